video_timing_generator: RTL and testbench

VIDEO_TIMING_GENERATOR -- requirements
Module: video_timing_generator

---
 rtl/video_timing_generator_pkg.sv | 14 +
 rtl/test_pattern_gen.sv | 43 ++++
 rtl/video_timing_generator.sv | 128 ++++++++++++
 tb/tb_video_timing_generator.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/video_timing_generator_pkg.sv
// Shared constants and helpers for the video timing generator and its pattern source.
package video_timing_generator_pkg;

  localparam logic [1:0] PAT_BARS  = 2'd0;
  localparam logic [1:0] PAT_GRAD  = 2'd1;
  localparam logic [1:0] PAT_CHECK = 2'd2;
  localparam logic [1:0] PAT_BLACK = 2'd3;

  function automatic int unsigned vtg_total(input int unsigned active, input int unsigned fp,
                                            input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/test_pattern_gen.sv
// Combinational test pattern source; only present when VTG_TEST_PATTERN_EN is defined.
`ifdef VTG_TEST_PATTERN_EN
module test_pattern_gen
  import video_timing_generator_pkg::*;
#(
  parameter int unsigned H_ACTIVE     = 640,
  parameter int unsigned NUM_CHANNELS = 3,
  parameter int unsigned COLOR_DEPTH  = 8,
  parameter int unsigned HW           = 10,
  parameter int unsigned VW           = 10
) (
  input  logic [HW-1:0]                       i_h_cnt,
  input  logic [VW-1:0]                       i_v_cnt,
  input  logic [1:0]                          i_pattern,
  output logic [NUM_CHANNELS*COLOR_DEPTH-1:0] o_pixel
);

  logic [2:0]             w_bar;
  logic [COLOR_DEPTH-1:0] w_grad;
  logic                   w_check;
  logic                   w_unused_v_cnt;

  // Bar index is only meaningful inside the active region; blanking masks the rest.
  assign w_bar          = 3'((32'(i_h_cnt) * 32'd8) / H_ACTIVE);
  assign w_grad         = COLOR_DEPTH'(i_h_cnt);
  assign w_check        = i_h_cnt[3] ^ i_v_cnt[3];
  assign w_unused_v_cnt = ^i_v_cnt;

  always_comb begin
    o_pixel = '0;
    for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
      unique case (i_pattern)
        PAT_BARS:  o_pixel[c*COLOR_DEPTH +: COLOR_DEPTH] = {COLOR_DEPTH{w_bar[c % 3]}};
        PAT_GRAD:  o_pixel[c*COLOR_DEPTH +: COLOR_DEPTH] = w_grad;
        PAT_CHECK: o_pixel[c*COLOR_DEPTH +: COLOR_DEPTH] = {COLOR_DEPTH{w_check}};
        PAT_BLACK: o_pixel[c*COLOR_DEPTH +: COLOR_DEPTH] = '0;
        default:   o_pixel[c*COLOR_DEPTH +: COLOR_DEPTH] = '0;
      endcase
    end
  end

endmodule
`endif

// File: rtl/video_timing_generator.sv
// Raster timing generator with registered DE/sync/pixel outputs.
// Define VTG_TEST_PATTERN_EN to enable selectable test patterns; otherwise active video is white.
module video_timing_generator
  import video_timing_generator_pkg::*;
#(
  parameter int unsigned H_ACTIVE     = 640,
  parameter int unsigned H_FP         = 16,
  parameter int unsigned H_SYNC       = 96,
  parameter int unsigned H_BP         = 48,
  parameter int unsigned V_ACTIVE     = 480,
  parameter int unsigned V_FP         = 10,
  parameter int unsigned V_SYNC       = 2,
  parameter int unsigned V_BP         = 33,
  parameter bit          HSYNC_POL    = 1'b0,
  parameter bit          VSYNC_POL    = 1'b0,
  parameter int unsigned NUM_CHANNELS = 3,
  parameter int unsigned COLOR_DEPTH  = 8
) (
  input  logic                                pixel_clk,
  input  logic                                rst_n,
  input  logic                                en,
  input  logic [1:0]                          pattern_sel,
  output logic                                de,
  output logic                                hsync,
  output logic                                vsync,
  output logic [3:0]                          ctl,
  output logic [NUM_CHANNELS*COLOR_DEPTH-1:0] pixel_data,
  output logic                                frame_start
);

  localparam int unsigned H_TOTAL = vtg_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = vtg_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int unsigned HW      = $clog2(H_TOTAL);
  localparam int unsigned VW      = $clog2(V_TOTAL);
  localparam int unsigned PW      = NUM_CHANNELS * COLOR_DEPTH;

  logic [HW-1:0] r_h_cnt;
  logic [VW-1:0] r_v_cnt;
  logic          w_de;
  logic          w_hs_act;
  logic          w_vs_act;
  logic          w_first;
  logic [PW-1:0] w_pixel;

  logic          r_de;
  logic          r_hsync;
  logic          r_vsync;
  logic [PW-1:0] r_pixel;
  logic          r_frame_start;

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (!en) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (32'(r_h_cnt) == H_TOTAL - 1) begin
      r_h_cnt <= '0;
      r_v_cnt <= (32'(r_v_cnt) == V_TOTAL - 1) ? '0 : r_v_cnt + 1'b1;
    end else begin
      r_h_cnt <= r_h_cnt + 1'b1;
    end
  end

  // Comparisons are done at 32 bits so range ends equal to 2**HW do not wrap.
  assign w_de     = (32'(r_h_cnt) < H_ACTIVE) && (32'(r_v_cnt) < V_ACTIVE);
  assign w_hs_act = (32'(r_h_cnt) >= H_ACTIVE + H_FP) &&
                    (32'(r_h_cnt) <  H_ACTIVE + H_FP + H_SYNC);
  assign w_vs_act = (32'(r_v_cnt) >= V_ACTIVE + V_FP) &&
                    (32'(r_v_cnt) <  V_ACTIVE + V_FP + V_SYNC);
  assign w_first  = (r_h_cnt == '0) && (r_v_cnt == '0);

`ifdef VTG_TEST_PATTERN_EN
  logic [1:0] r_pattern_q;

  // Latched only at the frame origin so a frame never mixes two patterns.
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pattern_q <= PAT_BARS;
    end else if (w_first) begin
      r_pattern_q <= pattern_sel;
    end
  end

  test_pattern_gen #(
    .H_ACTIVE     (H_ACTIVE),
    .NUM_CHANNELS (NUM_CHANNELS),
    .COLOR_DEPTH  (COLOR_DEPTH),
    .HW           (HW),
    .VW           (VW)
  ) u_test_pattern_gen (
    .i_h_cnt   (r_h_cnt),
    .i_v_cnt   (r_v_cnt),
    .i_pattern (r_pattern_q),
    .o_pixel   (w_pixel)
  );
`else
  logic w_unused_pattern_sel;

  assign w_unused_pattern_sel = ^pattern_sel;
  assign w_pixel              = '1;
`endif

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_de          <= 1'b0;
      r_hsync       <= ~HSYNC_POL;
      r_vsync       <= ~VSYNC_POL;
      r_pixel       <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_de          <= en & w_de;
      r_hsync       <= (en & w_hs_act) ? HSYNC_POL : ~HSYNC_POL;
      r_vsync       <= (en & w_vs_act) ? VSYNC_POL : ~VSYNC_POL;
      r_pixel       <= (en & w_de) ? w_pixel : '0;
      r_frame_start <= en & w_first;
    end
  end

  assign de          = r_de;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign ctl         = 4'b0000;
  assign pixel_data  = r_pixel;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_video_timing_generator.sv
// Randomised bench for video_timing_generator against a raster-index reference model.
module tb_video_timing_generator;

`ifdef VTG_TEST_PATTERN_EN
  localparam bit          HPOL = 1'b0;
  localparam int unsigned NCH  = 3;
`else
  localparam bit          HPOL = 1'b1;
  localparam int unsigned NCH  = 4;
`endif
  localparam bit VPOL  = 1'b0;
  localparam int CD    = 8;
  localparam int PW    = NCH * CD;
  localparam int HA    = 64;
  localparam int HF    = 4;
  localparam int HS    = 8;
  localparam int HB    = 4;
  localparam int VA    = 48;
  localparam int VF    = 2;
  localparam int VS    = 2;
  localparam int VB    = 3;
  localparam int HT    = HA + HF + HS + HB;
  localparam int VT    = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b1;
  logic [1:0]    pattern_sel = 2'd0;
  logic          de;
  logic          hsync;
  logic          vsync;
  logic [3:0]    ctl;
  logic [PW-1:0] pixel_data;
  logic          frame_start;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;
  int pos     = 0;
`ifdef VTG_TEST_PATTERN_EN
  int frame_pat = 0;
`endif

  video_timing_generator #(
    .H_ACTIVE     (HA),
    .H_FP         (HF),
    .H_SYNC       (HS),
    .H_BP         (HB),
    .V_ACTIVE     (VA),
    .V_FP         (VF),
    .V_SYNC       (VS),
    .V_BP         (VB),
    .HSYNC_POL    (HPOL),
    .VSYNC_POL    (VPOL),
    .NUM_CHANNELS (NCH),
    .COLOR_DEPTH  (CD)
  ) dut (
    .pixel_clk   (clk),
    .rst_n       (rst_n),
    .en          (en),
    .pattern_sel (pattern_sel),
    .de          (de),
    .hsync       (hsync),
    .vsync       (vsync),
    .ctl         (ctl),
    .pixel_data  (pixel_data),
    .frame_start (frame_start)
  );

  initial forever #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [63:0] pack(input logic fs, input logic d, input logic hs,
                                       input logic vs, input logic [3:0] c,
                                       input logic [PW-1:0] px);
    return 64'({fs, d, hs, vs, c, px});
  endfunction

  function automatic logic [63:0] outs();
    return pack(frame_start, de, hsync, vsync, ctl, pixel_data);
  endfunction

  function automatic logic [63:0] idle_bundle();
    return pack(1'b0, 1'b0, ~HPOL, ~VPOL, 4'b0000, '0);
  endfunction

  // Expected pixel for raster position (h, v) in the frame's pattern.
  function automatic logic [PW-1:0] exp_pixel(input int h, input int v);
    logic [PW-1:0] px;
    px = '0;
    if (h < HA && v < VA) begin
`ifdef VTG_TEST_PATTERN_EN
      for (int c = 0; c < NCH; c++) begin
        case (frame_pat)
          0: if ((((h * 8) / HA) >> (c % 3)) & 1) px[c*CD +: CD] = '1;
          1: px[c*CD +: CD] = CD'(h % 256);
          2: if (((h / 8) ^ (v / 8)) & 1) px[c*CD +: CD] = '1;
          default: px[c*CD +: CD] = '0;
        endcase
      end
`else
      px = '1;
`endif
    end
    return px;
  endfunction

  // Advance one clock; the model tracks a flat raster index for the pixel being output.
  task automatic step(input string tag);
    logic [63:0] exp;
    int h;
    int v;
    @(posedge clk);
    #1;
    cyc++;
    if (!rst_n || !en) begin
      exp = idle_bundle();
      pos = 0;
    end else begin
      h = pos % HT;
      v = pos / HT;
`ifdef VTG_TEST_PATTERN_EN
      if (pos == 0) frame_pat = int'(pattern_sel);
`endif
      exp = pack(pos == 0, (h < HA) && (v < VA),
                 (h >= HA + HF && h < HA + HF + HS) ? HPOL : ~HPOL,
                 (v >= VA + VF && v < VA + VF + VS) ? VPOL : ~VPOL,
                 4'b0000, exp_pixel(h, v));
      pos = (pos + 1) % FRAME;
    end
    check_eq(tag, outs(), exp);
  endtask

  initial begin
    int de_cnt;
    int hs_cnt;
    int vs_cnt;
    int de_lines;
    int hs_first;
    int vs_first;
    int fs_a;
    int fs_b;
    logic prev_de;

    repeat (3) step("reset");
    rst_n = 1'b1;

    de_cnt = 0; hs_cnt = 0; vs_cnt = 0; de_lines = 0;
    hs_first = -1; vs_first = -1; fs_a = -1; fs_b = -1; prev_de = 1'b0;
    for (int k = 0; k <= 2 * FRAME; k++) begin
      step("two_frames");
      if (k < FRAME) begin
        if (de) de_cnt++;
        if (de && !prev_de) de_lines++;
        if (hsync == HPOL) begin
          hs_cnt++;
          if (hs_first < 0) hs_first = k;
        end
        if (vsync == VPOL) begin
          vs_cnt++;
          if (vs_first < 0) vs_first = k;
        end
      end
      prev_de = de;
      if (frame_start) begin
        if (fs_a < 0) fs_a = cyc;
        else if (fs_b < 0) fs_b = cyc;
      end
    end
    check_eq("de_per_frame", 64'(de_cnt), 64'(HA * VA));
    check_eq("de_lines", 64'(de_lines), 64'(VA));
    check_eq("hsync_cycles", 64'(hs_cnt), 64'(HS * VT));
    check_eq("vsync_cycles", 64'(vs_cnt), 64'(VS * HT));
    check_eq("hsync_start", 64'(hs_first), 64'(HA + HF));
    check_eq("vsync_start", 64'(vs_first), 64'((VA + VF) * HT));
    check_eq("frame_period", 64'(fs_b - fs_a), 64'(FRAME));

    // Gradient requested, switched to checkerboard mid-frame.
    pattern_sel = 2'd1;
    while (pos != 0) step("pat_grad_wait");
    step("pat_grad");
    while (pos != (VA / 2) * HT) step("pat_grad");
    pattern_sel = 2'd2;
    while (pos != 0) step("pat_grad_tail");
    repeat (FRAME) step("pat_check");

    // Enable dropped mid-line, then restored.
    while (pos != 10 * HT + 20) step("en_wait");
    en = 1'b0;
    repeat (7) step("en_idle");
    en = 1'b1;
    step("en_restart");
    check_eq("restart_fs", 64'(frame_start), 64'(1));
    check_eq("restart_de", 64'(de), 64'(1));
    repeat (300) step("en_run");

    // Asynchronous reset in the middle of a frame.
    while (pos != 30 * HT + 5) step("rst_wait");
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rst_immediate", outs(), idle_bundle());
    repeat (3) step("rst_hold");
    rst_n = 1'b1;
    step("rst_release");
    check_eq("rst_release_fs", 64'(frame_start), 64'(1));
    repeat (500) step("rst_run");

    for (int i = 0; i < 15000; i++) begin
      step("random");
      if (!rst_n) begin
        rst_n = 1'b1;
      end else if ($urandom_range(0, 1999) == 0) begin
        rst_n = 1'b0;
        #1;
        check_eq("rst_async", outs(), idle_bundle());
      end
      if (en) begin
        if ($urandom_range(0, 499) == 0) en = 1'b0;
      end else if ($urandom_range(0, 7) == 0) begin
        en = 1'b1;
      end
      if ($urandom_range(0, 299) == 0) pattern_sel = 2'($urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
